// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps a payload byte stream with preamble, SFD,
// optional zero padding and CRC-32 FCS, then holds the line idle for the
// inter-frame gap. An upstream underrun aborts the frame with a tx_er cycle.
// All wire outputs are registered: the FSM state names the byte being
// produced for the next cycle, not the byte currently on txd.
module eth_tx_framer #(
   parameter int unsigned IFG_CYCLES  = 12,
   parameter int unsigned MIN_PAYLOAD = 60,
   parameter bit          PAD_EN      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] txd,
   output logic       tx_en,
   output logic       tx_er,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_PAYLOAD,
      ST_PAD,
      ST_FCS,
      ST_DRAIN,
      ST_IFG
   } state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY_REV  = 32'hEDB8_8320;
   localparam logic [16:0] MIN_LEN       = 17'(MIN_PAYLOAD);
   localparam logic [7:0]  IFG_LAST      = 8'(IFG_CYCLES - 1);
   // The IDLE exit emits the first preamble byte, so PREAMBLE emits the other six.
   localparam logic [7:0]  PRE_LAST      = 8'd6;

   state_t      state_q, state_d;
   logic [7:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [15:0] byte_cnt_inc;
   logic [16:0] byte_cnt_next;
   logic [31:0] fcs;

   // One byte step of the reflected IEEE 802.3 CRC-32 (LSB of each byte first).
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REV) : (c >> 1);
      end
      return c;
   endfunction

   // Frame byte counter saturates so very long frames never wrap into "short".
   assign byte_cnt_inc  = (byte_cnt_q == 16'hFFFF) ? 16'hFFFF : byte_cnt_q + 16'd1;
   // Unsaturated count including the byte being sent now, used for pad decisions.
   assign byte_cnt_next = {1'b0, byte_cnt_q} + 17'd1;
   assign fcs           = ~crc_q;

   assign txd     = txd_q;
   assign tx_en   = tx_en_q;
   assign tx_er   = tx_er_q;
   assign s_ready = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
   assign busy    = (state_q != ST_IDLE);

   // Next-state and next-output decode; every path defaults to an idle wire.
   always_comb begin
      state_d    = state_q;
      txd_d      = 8'h00;
      tx_en_d    = 1'b0;
      tx_er_d    = 1'b0;
      crc_d      = crc_q;
      byte_cnt_d = byte_cnt_q;
      cnt_d      = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               txd_d   = PREAMBLE_BYTE;
               tx_en_d = 1'b1;
               cnt_d   = 8'd1;
               state_d = ST_PREAMBLE;
            end
         end

         ST_PREAMBLE: begin
            txd_d   = PREAMBLE_BYTE;
            tx_en_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == PRE_LAST) begin
               state_d = ST_SFD;
            end
         end

         ST_SFD: begin
            txd_d      = SFD_BYTE;
            tx_en_d    = 1'b1;
            crc_d      = CRC_INIT;
            byte_cnt_d = 16'd0;
            cnt_d      = 8'd0;
            state_d    = ST_PAYLOAD;
         end

         ST_PAYLOAD: begin
            tx_en_d = 1'b1;
            if (s_valid) begin
               txd_d      = s_data;
               crc_d      = crc32_byte(crc_q, s_data);
               byte_cnt_d = byte_cnt_inc;
               if (s_last) begin
                  cnt_d = 8'd0;
                  if (PAD_EN && (byte_cnt_next < MIN_LEN)) begin
                     state_d = ST_PAD;
                  end else begin
                     state_d = ST_FCS;
                  end
               end
            end else begin
               // Underrun: flag the frame bad for one cycle and swallow the rest.
               txd_d   = 8'h00;
               tx_er_d = 1'b1;
               state_d = ST_DRAIN;
            end
         end

         ST_PAD: begin
            txd_d      = 8'h00;
            tx_en_d    = 1'b1;
            crc_d      = crc32_byte(crc_q, 8'h00);
            byte_cnt_d = byte_cnt_inc;
            if (byte_cnt_next >= MIN_LEN) begin
               cnt_d   = 8'd0;
               state_d = ST_FCS;
            end
         end

         ST_FCS: begin
            tx_en_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            case (cnt_q[1:0])
               2'd0:    txd_d = fcs[7:0];
               2'd1:    txd_d = fcs[15:8];
               2'd2:    txd_d = fcs[23:16];
               default: txd_d = fcs[31:24];
            endcase
            if (cnt_q[1:0] == 2'd3) begin
               cnt_d   = 8'd0;
               state_d = ST_IFG;
            end
         end

         ST_DRAIN: begin
            if (s_valid && s_last) begin
               cnt_d   = 8'd0;
               state_d = ST_IFG;
            end
         end

         ST_IFG: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == IFG_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, wire outputs, CRC and counters; async reset forces a quiet line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         txd_q      <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         crc_q      <= CRC_INIT;
         byte_cnt_q <= 16'd0;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         txd_q      <= txd_d;
         tx_en_q    <= tx_en_d;
         tx_er_q    <= tx_er_d;
         crc_q      <= crc_d;
         byte_cnt_q <= byte_cnt_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Ethernet transmit framer sitting directly upstream of the PHY byte interface. It owns the CRC-32 byte engine's feed path.
- Accepts a payload byte stream from the MAC packet buffer: destination address through end of payload, no preamble, no FCS.
- Emits a GMII-style byte stream in this order: 7 preamble bytes, SFD, payload, zero padding up to the minimum frame size, 4-byte FCS, then enforces the inter-frame gap.

Parameters:
- IFG_CYCLES, 12, idle cycles (tx_en=0) forced after each frame's last FCS byte; legal range 1..255.
- MIN_PAYLOAD, 60, minimum bytes between SFD and FCS; shorter frames are zero-padded; legal range 1..65535.
- PAD_EN, 1, 1 = pad short frames to MIN_PAYLOAD; 0 = never pad.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  8  payload byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final payload byte of the frame; qualified by s_valid.
- s_ready  out  1  framer accepts s_data this cycle.
- txd  out  8  transmit byte to PHY.
- tx_en  out  1  txd carries a frame byte.
- tx_er  out  1  frame error (underrun abort).
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE; txd=0x00, tx_en=0, tx_er=0, s_ready=0, busy=0; CRC register=0xFFFFFFFF; counters=0.
- Outputs txd/tx_en/tx_er are registered. s_ready is decoded from state: 1 only in PAYLOAD and DRAIN.
- Handshake: a byte transfers when s_valid & s_ready. Upstream must hold s_data/s_last stable while s_valid=1 and s_ready=0.
- IDLE: s_valid=1 -> PREAMBLE. The next cycle shows tx_en=1, txd=0x55.
- PREAMBLE: 7 cycles, txd=0x55. Then SFD: 1 cycle, txd=0xD5. CRC is initialised to 0xFFFFFFFF here.
- PAYLOAD:
  - Transfer -> next cycle txd=s_data, tx_en=1. CRC updated with the byte; the 16-bit byte counter increments (saturating at 0xFFFF).
  - Transfer with s_last=1: if PAD_EN=1 and count+1 < MIN_PAYLOAD -> PAD, else -> FCS.
  - Underrun (s_valid=0 in PAYLOAD): next cycle tx_en=1, tx_er=1, txd=0x00 for exactly one cycle, then tx_en=0 and state DRAIN. The CRC is not emitted.
- PAD: txd=0x00, CRC updated with 0x00, counter increments until count==MIN_PAYLOAD, then FCS.
- CRC and FCS encoding:
  - CRC is IEEE 802.3 CRC-32, polynomial 0x04C11DB7, reflected (LSB-first per byte), init all-ones.
  - FCS = bitwise NOT of the final register, sent least-significant byte first over 4 cycles.
  - Check value: payload ASCII "123456789" -> FCS bytes 0x26,0x39,0xF4,0xCB.
- FCS -> IFG: tx_en=0, txd=0x00 for IFG_CYCLES cycles, then IDLE. s_valid during IFG is ignored (s_ready=0).
- DRAIN: s_ready=1. Bytes are discarded until a transfer with s_last=1, then IFG.
- Frame length rule: tx_en stays high contiguously for 8+max(N, MIN_PAYLOAD when PAD_EN)+4 cycles; no gaps inside a frame.
- Back-to-back frames: the next preamble starts exactly IFG_CYCLES+1 cycles after the last FCS byte if s_valid is already high in IDLE.
- Reset mid-frame: outputs drop immediately to reset values. No FCS or tx_er is emitted. Upstream is responsible for its own flush.
- busy=1 in every state except IDLE.

Test Plan:
- PAD_EN=0, payload "123456789" (9 bytes, s_last on '9') -> txd: 55×7, D5, 31..39, 26 39 F4 CB. tx_en high 21 cycles, then 12 cycles low.
- PAD_EN=1, MIN_PAYLOAD=60, 14-byte payload -> 46 bytes of 0x00 follow the payload. FCS is computed over all 60 bytes and matches the software model. tx_en high 72 cycles.
- Two 64-byte frames with s_valid held high throughout -> tx_en low for exactly 12 cycles between frames. No byte lost; s_ready low during preamble, SFD, FCS and IFG.
- s_valid dropped at payload byte 20 -> one cycle tx_en=1, tx_er=1, then tx_en=0. The remaining 30 bytes through s_last are accepted and discarded. The next frame starts after the IFG.
- rst_n asserted during FCS byte 2 -> txd=0, tx_en=0, busy=0 the same cycle (async). After release, a new frame transmits normally with the correct FCS.
- s_valid asserted during IFG -> s_ready stays 0, and PREAMBLE starts only after the IFG count completes.
